btn_event_decoder: RTL and testbench

- Consumes one debounced, active-low button level (e.g. the output of the debouncing stage) and turns it into single-cycle events: short press, long press, and auto-repeat while held.
- Sits between the button debounce stage and the Tamagotchi control FSM.
- The control FSM only ever sees one-cycle pulses, never raw levels.

---
 rtl/btn_pkg.sv | 16 +
 rtl/btn_sync.sv | 20 ++
 rtl/btn_event_decoder.sv | 126 ++++++++++++
 tb/tb_btn_event_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: decoder state encoding and default timing shared by the button chain.
package btn_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESSED  = 3'd1,
      HELD     = 3'd2,
      WAIT2    = 3'd3,
      WAIT_REL = 3'd4
   } state_t;
   localparam int LONG_COUNT_DEF   = 150000000;
   localparam int REPEAT_COUNT_DEF = 25000000;
   localparam int DCLICK_COUNT_DEF = 15000000;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchronizer with a configurable reset value.
module btn_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic s1_q, s2_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   assign q = s2_q;
endmodule

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a debounced active-low button into short/long/repeat pulses.
// Define DCLICK_EN to add double-click detection (WAIT2/WAIT_REL states, double_pulse).
module btn_event_decoder
   import btn_pkg::*;
#(
   parameter int LONG_COUNT   = LONG_COUNT_DEF,
   parameter int REPEAT_COUNT = REPEAT_COUNT_DEF,
   parameter int DCLICK_COUNT = DCLICK_COUNT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic boton_in,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held,
   output logic double_pulse
);
   localparam int CW = $clog2(max3(LONG_COUNT, REPEAT_COUNT, DCLICK_COUNT)) + 1;
   logic sync_out, pressed;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic short_q, short_d, long_q, long_d, rep_q, rep_d, held_q;
`ifdef DCLICK_EN
   logic dbl_q, dbl_d;
`endif
   btn_sync #(.RST_VAL(1'b1)) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (boton_in),
      .q  (sync_out)
   );
   assign pressed = ~sync_out;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
`ifdef DCLICK_EN
      dbl_d   = 1'b0;
`endif
      case (state_q)
         IDLE:
            if (pressed) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end
         PRESSED:
            if (!pressed) begin
`ifdef DCLICK_EN
               state_d = WAIT2;
`else
               state_d = IDLE;
               short_d = 1'b1;
`endif
               cnt_d   = '0;
            end else if (cnt_q == CW'(LONG_COUNT - 1)) begin
               state_d = HELD;
               long_d  = 1'b1;
               cnt_d   = '0;
            end else
               cnt_d = cnt_q + 1'b1;
         HELD:
            if (!pressed) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(REPEAT_COUNT - 1)) begin
               rep_d = 1'b1;
               cnt_d = '0;
            end else
               cnt_d = cnt_q + 1'b1;
`ifdef DCLICK_EN
         // Window expiry wins over a press landing on the very last cycle.
         WAIT2:
            if (cnt_q == CW'(DCLICK_COUNT - 1)) begin
               state_d = IDLE;
               short_d = 1'b1;
               cnt_d   = '0;
            end else if (pressed) begin
               state_d = WAIT_REL;
               dbl_d   = 1'b1;
               cnt_d   = '0;
            end else
               cnt_d = cnt_q + 1'b1;
         WAIT_REL:
            if (!pressed) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
`endif
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         short_q <= short_d;
         long_q  <= long_d;
         rep_q   <= rep_d;
         held_q  <= (state_d == HELD);
      end
`ifdef DCLICK_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) dbl_q <= 1'b0;
      else     dbl_q <= dbl_d;
   assign double_pulse = dbl_q;
`else
   assign double_pulse = 1'b0;
`endif
   assign short_pulse  = short_q;
   assign long_pulse   = long_q;
   assign repeat_pulse = rep_q;
   assign held         = held_q;
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed presses with a cycle-stamped event scoreboard.
module tb_btn_event_decoder;
   localparam int L = 10, R = 4, D = 6;
   localparam int E_SHORT = 1, E_LONG = 2, E_REP = 3, E_DBL = 4, E_HUP = 5, E_HDN = 6;
   logic clk = 1'b0, rst = 1'b1, boton_in = 1'b1;
   logic short_pulse, long_pulse, repeat_pulse, held, double_pulse;
   typedef struct {int code; int cyc;} ev_t;
   ev_t q[$];
   int cyc = 0, checks = 0, fails = 0;
   always #5 clk = ~clk;
   btn_event_decoder #(.LONG_COUNT(L), .REPEAT_COUNT(R), .DCLICK_COUNT(D)) dut (
      .clk(clk), .rst(rst), .boton_in(boton_in), .short_pulse(short_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held),
      .double_pulse(double_pulse)
   );
   function automatic string nm(input int c);
      return c == E_SHORT ? "short" : c == E_LONG ? "long" : c == E_REP ? "repeat" :
             c == E_DBL ? "double" : c == E_HUP ? "held_rise" : "held_fall";
   endfunction
   task automatic push(input int c, input int t);
      q.push_back('{code: c, cyc: t});
   endtask
   // Button low for edges t0..t0+n-1; the decoder sees it two edges later.
   task automatic exp_press(input int t0, input int n);
      if (n >= L + 1) begin
         push(E_LONG, t0 + L + 2);
         push(E_HUP, t0 + L + 2);
         for (int t = t0 + L + 2 + R; t <= t0 + n + 1; t += R) push(E_REP, t);
         push(E_HDN, t0 + n + 2);
      end else begin
`ifdef DCLICK_EN
         push(E_SHORT, t0 + n + 2 + D);
`else
         push(E_SHORT, t0 + n + 2);
`endif
      end
   endtask
   task automatic press(input int n, input int gap);
      int t0;
      @(negedge clk);
      boton_in = 1'b0;
      t0 = cyc + 1;
      exp_press(t0, n);
      repeat (n) @(negedge clk);
      boton_in = 1'b1;
      repeat (gap) @(negedge clk);
   endtask
   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask
   initial forever @(posedge clk) cyc++;
   initial begin
      int prev_held = 0;
      forever begin
         bit [6:1] o;
         int npulse;
         @(negedge clk);
         o[1] = short_pulse === 1'b1;
         o[2] = long_pulse === 1'b1;
         o[3] = repeat_pulse === 1'b1;
         o[4] = double_pulse === 1'b1;
         o[5] = (held === 1'b1) && prev_held == 0;
         o[6] = (held !== 1'b1) && prev_held == 1;
         prev_held = (held === 1'b1) ? 1 : 0;
         npulse = int'(o[1]) + int'(o[2]) + int'(o[3]) + int'(o[4]);
         checks++;
         if (npulse > 1) begin
            fails++;
            $display("FAIL exclusion at cycle %0d: %0d pulses high, allowed 1", cyc, npulse);
         end
         for (int c = 1; c <= 6; c++) if (o[c]) begin
            int idx = -1;
            foreach (q[i]) if (idx < 0 && q[i].code == c && q[i].cyc == cyc) idx = i;
            checks++;
            if (idx < 0) begin
               fails++;
               $display("FAIL unexpected %s at cycle %0d: seen, required none", nm(c), cyc);
            end else q.delete(idx);
         end
         for (int i = q.size() - 1; i >= 0; i--) if (q[i].cyc <= cyc) begin
            checks++;
            fails++;
            $display("FAIL missing %s: absent at cycle %0d, required at %0d", nm(q[i].code), cyc, q[i].cyc);
            q.delete(i);
         end
      end
   end
   initial begin
      int t0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {short_pulse, long_pulse, repeat_pulse, double_pulse, held}, 5'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      press(5, 12);
      press(L, 12);
      press(L + 1, 12);
      press(32, 12);
      @(negedge clk);
      boton_in = 1'b0;
      t0 = cyc + 1;
      push(E_LONG, t0 + L + 2);
      push(E_HUP, t0 + L + 2);
      repeat (L + 3) @(negedge clk);
      chk("held_before_rst", {long_pulse, held}, 2'b11);
      #1 rst = 1'b1;
      #1 chk("async_rst_clear", {short_pulse, long_pulse, repeat_pulse, double_pulse, held}, 5'b0);
      push(E_HDN, cyc + 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      t0 = cyc + 1;
      exp_press(t0, 15);
      repeat (15) @(negedge clk);
      boton_in = 1'b1;
      repeat (12) @(negedge clk);
`ifdef DCLICK_EN
      @(negedge clk);
      boton_in = 1'b0;
      t0 = cyc + 1;
      push(E_DBL, t0 + 7);
      repeat (3) @(negedge clk);
      boton_in = 1'b1;
      repeat (2) @(negedge clk);
      boton_in = 1'b0;
      repeat (2) @(negedge clk);
      boton_in = 1'b1;
      repeat (15) @(negedge clk);
      @(negedge clk);
      boton_in = 1'b0;
      t0 = cyc + 1;
      push(E_SHORT, t0 + 11);
      push(E_SHORT, t0 + 20);
      repeat (3) @(negedge clk);
      boton_in = 1'b1;
      repeat (7) @(negedge clk);
      boton_in = 1'b0;
      repeat (2) @(negedge clk);
      boton_in = 1'b1;
      repeat (20) @(negedge clk);
`endif
      repeat (20) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expected events outstanding, required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
